stp_min_sec_chain: RTL and testbench
====================================

STP_MIN_SEC_CHAIN -- requirements
Module: stp_min_sec_chain

Interface
REQ-001 Parameter: TICKS_PER_SEC, default 50_000_000, CLK cycles per stopwatch second (minimum 2).
REQ-002 Parameter: PRESC_W, default 26, prescaler width; SHALL satisfy 2^PRESC_W >= TICKS_PER_SEC.
REQ-003 CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  synchronous start/resume request, sampled each edge.
REQ-006 pause  input  1  synchronous pause request, sampled each edge.
REQ-007 clear  input  1  synchronous clear request, sampled each edge.
REQ-008 sec  output  8  seconds count, binary 0..59.
REQ-009 min  output  8  minutes count, binary 0..59.
REQ-010 count_up_hr  output  1  one-cycle pulse that advances the downstream 24-hour counter.
REQ-011 rst_counters  output  1  one-cycle pulse that clears the downstream 24-hour counter.
REQ-012 running  output  1  high while the FSM is in RUN.

Function
REQ-013 FSM SHALL have three states: IDLE, RUN and PAUSE.
REQ-014 Transition priority SHALL be clear > pause > start.
REQ-015 clear SHALL move the FSM from any state to IDLE; at the same edge prescaler, sec and min SHALL load 0.
REQ-016 pause SHALL move RUN to PAUSE; in IDLE or PAUSE it SHALL have no effect.
REQ-017 start SHALL move IDLE or PAUSE to RUN; in RUN it SHALL have no effect.
REQ-018 Prescaler SHALL increment only at edges where the current state is RUN; it SHALL hold its value in PAUSE and hold 0 in IDLE.
REQ-019 A tick SHALL occur at an edge where the state is RUN and the prescaler equals TICKS_PER_SEC-1; the prescaler SHALL wrap to 0 at that edge.
REQ-020 Counting at a tick: if sec<59, sec+1; if sec==59 and min<59, sec=0 and min+1; if sec==59 and min==59, sec=0 and min=0.
REQ-021 count_up_hr SHALL be registered and high for exactly the one cycle after the edge at which sec and min both wrap to 0; it SHALL be 0 at all other times.
REQ-022 rst_counters SHALL be registered and high for exactly the one cycle after each edge at which clear is sampled high; it SHALL be low otherwise.
REQ-023 rst_counters SHALL pulse on every edge at which clear is sampled high, regardless of state.
REQ-024 Simultaneous clear and tick: clear SHALL win; no increment SHALL occur and count_up_hr SHALL stay 0.
REQ-025 Simultaneous pause and tick in RUN: the tick SHALL be counted at that edge, then the FSM SHALL enter PAUSE.
REQ-026 Resume from PAUSE SHALL continue from the held prescaler value, so no partial second is lost or added.
REQ-027 sec and min SHALL never leave the range 0..59.
REQ-028 The upper two bits of sec and min SHALL be 0.
REQ-029 running SHALL be combinationally decoded from the registered state.

Reset
REQ-030 While rst_n is low, asynchronously: FSM=IDLE, prescaler=0, sec=0, min=0, count_up_hr=0, rst_counters=0, running=0.
REQ-031 Reset asserted mid-operation SHALL abort any pending pulse.
REQ-032 After rst_n deasserts, the block SHALL remain in IDLE until start is sampled high.

Verification (TICKS_PER_SEC=4)
REQ-033 After reset, pulse start once and wait 8 cycles -> running=1, sec=2, min=0.
REQ-034 Preload a run to min=59, sec=59 with prescaler at 3, then wait one edge -> sec=0, min=0, count_up_hr=1 for exactly one cycle.
REQ-035 In RUN with prescaler=2, assert pause, hold 10 cycles, then assert start -> sec unchanged while paused; the next tick occurs 2 cycles after resume.
REQ-036 At an edge where a tick is due, assert clear -> sec=0, min=0, FSM=IDLE, rst_counters=1 for one cycle, count_up_hr=0.
REQ-037 Assert start, pause and clear in the same cycle -> IDLE, rst_counters pulses, running=0.
REQ-038 Assert rst_n low for 1 cycle while count_up_hr=1 -> all outputs 0 immediately; block in IDLE afterwards.

Source files
------------

// File: rtl/stp_min_sec_chain.sv
`default_nettype none
// ============================================================================
//  Module   : stp_min_sec_chain
//  Purpose  : Stopwatch minutes/seconds stage. A prescaler derives one tick
//             per second from CLK while in RUN. Each tick advances a 0..59
//             seconds counter, then a 0..59 minutes counter. Registered
//             one-cycle pulses drive a downstream 24-hour counter: one
//             advances it on the 59:59 -> 00:00 rollover, and one clears it.
//  Revision : 1.0  initial release
// ============================================================================
module stp_min_sec_chain #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int PRESC_W       = 26
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic       count_up_hr,
  output logic       rst_counters,
  output logic       running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Terminal prescaler value; a tick is due when the prescaler reaches it
  localparam logic [PRESC_W-1:0] C_PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [PRESC_W-1:0] C_PRESC_ONE  = PRESC_W'(1);
  localparam logic [7:0]         C_LAST_UNIT  = 8'd59;

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [7:0]         sec_q,   sec_d;
  logic [7:0]         min_q,   min_d;
  logic               count_up_hr_q,  count_up_hr_d;
  logic               rst_counters_q, rst_counters_d;
  logic               tick;

  // A tick is only meaningful while the registered state is RUN
  assign tick = (state_q == RUN) && (presc_q == C_PRESC_LAST);

  // Next-state, prescaler and counter logic; clear overrides everything
  always_comb begin
    state_d        = state_q;
    presc_d        = presc_q;
    sec_d          = sec_q;
    min_d          = min_q;
    count_up_hr_d  = 1'b0;
    // The downstream clear pulse follows every sampled clear, whatever the state
    rst_counters_d = clear;

    if (clear) begin
      state_d = IDLE;
      presc_d = '0;
      sec_d   = '0;
      min_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (tick) begin
            presc_d = '0;
            if (sec_q < C_LAST_UNIT) begin
              sec_d = sec_q + 8'd1;
            end else begin
              sec_d = '0;
              if (min_q < C_LAST_UNIT) begin
                min_d = min_q + 8'd1;
              end else begin
                min_d         = '0;
                count_up_hr_d = 1'b1;
              end
            end
          end else begin
            presc_d = presc_q + C_PRESC_ONE;
          end
          // A pause coinciding with a tick still lets that tick count above
          if (pause) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          // Prescaler holds so a resume keeps the partial second
          if (start) begin
            state_d = RUN;
          end
        end
        default: begin
          presc_d = '0;
          if (start) begin
            state_d = RUN;
          end
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      presc_q        <= '0;
      sec_q          <= '0;
      min_q          <= '0;
      count_up_hr_q  <= 1'b0;
      rst_counters_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      sec_q          <= sec_d;
      min_q          <= min_d;
      count_up_hr_q  <= count_up_hr_d;
      rst_counters_q <= rst_counters_d;
    end
  end

  assign sec          = sec_q;
  assign min          = min_q;
  assign count_up_hr  = count_up_hr_q;
  assign rst_counters = rst_counters_q;
  assign running      = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_stp_min_sec_chain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stp_min_sec_chain
//  Purpose  : Directed self-checking bench for stp_min_sec_chain with a
//             four-cycle second.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stp_min_sec_chain;

  localparam int TPS = 4;

  logic       CLK;
  logic       rst_n;
  logic       start;
  logic       pause;
  logic       clear;
  logic [7:0] sec;
  logic [7:0] min;
  logic       count_up_hr;
  logic       rst_counters;
  logic       running;

  int vectors;
  int miscompares;

  stp_min_sec_chain #(
    .TICKS_PER_SEC(TPS),
    .PRESC_W      (3)
  ) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .start       (start),
    .pause       (pause),
    .clear       (clear),
    .sec         (sec),
    .min         (min),
    .count_up_hr (count_up_hr),
    .rst_counters(rst_counters),
    .running     (running)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance n rising edges, then settle 1 time unit before sampling
  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;

    // Reset state
    #3;
    chk8("rst_sec", sec, 8'd0);
    chk8("rst_min", min, 8'd0);
    chk1("rst_running", running, 1'b0);
    chk1("rst_cuh", count_up_hr, 1'b0);
    chk1("rst_rstc", rst_counters, 1'b0);
    edges(2);
    rst_n = 1'b1;
    edges(3);
    chk1("idle_after_rst_running", running, 1'b0);
    chk8("idle_after_rst_sec", sec, 8'd0);

    // Start pulse, then eight cycles make two seconds
    start = 1'b1;
    edges(1);
    start = 1'b0;
    chk1("start_running", running, 1'b1);
    edges(8);
    chk1("run8_running", running, 1'b1);
    chk8("run8_sec", sec, 8'd2);
    chk8("run8_min", min, 8'd0);

    // Pause with prescaler left at 2, hold 10 cycles, resume
    edges(1);                         // prescaler 0 -> 1
    pause = 1'b1;
    edges(1);                         // prescaler 1 -> 2, enter PAUSE
    chk1("pause_running", running, 1'b0);
    edges(9);
    pause = 1'b0;
    chk8("paused_sec", sec, 8'd2);
    chk1("paused_running", running, 1'b0);
    start = 1'b1;
    edges(1);
    start = 1'b0;
    chk1("resume_running", running, 1'b1);
    chk8("resume_sec", sec, 8'd2);
    edges(1);
    chk8("resume_plus1_sec", sec, 8'd2);
    edges(1);
    chk8("resume_plus2_sec", sec, 8'd3);

    // Pause on the same edge as a tick: tick counts, then PAUSE
    edges(3);
    chk8("pre_pause_tick_sec", sec, 8'd3);
    pause = 1'b1;
    edges(1);
    pause = 1'b0;
    chk8("pause_tick_sec", sec, 8'd4);
    chk1("pause_tick_running", running, 1'b0);
    edges(2);
    chk8("pause_tick_hold_sec", sec, 8'd4);
    start = 1'b1;
    edges(1);
    start = 1'b0;
    chk1("resume2_running", running, 1'b1);

    // Clear on the edge where a tick is due
    edges(3);
    chk8("pre_clear_sec", sec, 8'd4);
    clear = 1'b1;
    edges(1);
    clear = 1'b0;
    chk8("clear_sec", sec, 8'd0);
    chk8("clear_min", min, 8'd0);
    chk1("clear_running", running, 1'b0);
    chk1("clear_rstc", rst_counters, 1'b1);
    chk1("clear_cuh", count_up_hr, 1'b0);
    edges(1);
    chk1("clear_rstc_drop", rst_counters, 1'b0);
    edges(4);
    chk1("clear_stay_idle", running, 1'b0);
    chk8("clear_stay_sec", sec, 8'd0);

    // start, pause and clear together: clear wins
    start = 1'b1;
    pause = 1'b1;
    clear = 1'b1;
    edges(1);
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
    chk1("all3_running", running, 1'b0);
    chk1("all3_rstc", rst_counters, 1'b1);
    edges(1);
    chk1("all3_rstc_drop", rst_counters, 1'b0);
    chk1("all3_idle", running, 1'b0);

    // Full hour: run to 59:59, then the rollover pulse
    start = 1'b1;
    edges(1);
    start = 1'b0;
    edges(TPS * 60);
    chk8("one_min_sec", sec, 8'd0);
    chk8("one_min_min", min, 8'd1);
    edges(TPS * 3599 - TPS * 60);
    chk8("5959_sec", sec, 8'd59);
    chk8("5959_min", min, 8'd59);
    edges(TPS - 1);
    chk8("5959_hold_sec", sec, 8'd59);
    chk1("5959_cuh_low", count_up_hr, 1'b0);
    edges(1);
    chk8("wrap_sec", sec, 8'd0);
    chk8("wrap_min", min, 8'd0);
    chk1("wrap_cuh", count_up_hr, 1'b1);
    chk1("wrap_running", running, 1'b1);
    edges(1);
    chk1("wrap_cuh_drop", count_up_hr, 1'b0);

    // Second rollover, then async reset while count_up_hr is high
    edges(TPS * 3600 - 1);
    chk1("wrap2_cuh", count_up_hr, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("async_rst_cuh", count_up_hr, 1'b0);
    chk1("async_rst_running", running, 1'b0);
    chk1("async_rst_rstc", rst_counters, 1'b0);
    chk8("async_rst_sec", sec, 8'd0);
    chk8("async_rst_min", min, 8'd0);
    edges(1);
    rst_n = 1'b1;
    edges(3);
    chk1("post_rst_running", running, 1'b0);
    chk1("post_rst_cuh", count_up_hr, 1'b0);
    chk8("post_rst_sec", sec, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
